// File: rtl/param_sequence_detector.sv
// param_sequence_detector
// Runtime-configurable serial pattern detector. A legal configuration load
// arms the detector. Enabled input bits are then shifted into a history
// register and compared against the stored pattern. A registered pulse on z
// marks each match, and match_count saturates at its maximum value.
module param_sequence_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           x,
    input  logic                           en,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    output logic                           z,
    output logic [CNT_W-1:0]               match_count,
    output logic                           cfg_err,
    output logic                           armed
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [0:0] {
        S_UNCFG = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic [MAX_LEN-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 ovl_q, ovl_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 z_q, z_d;
    logic                 err_q, err_d;

    logic                 len_ok_s;
    logic [MAX_LEN-1:0]   shift_s;
    logic [MAX_LEN-1:0]   mask_s;
    logic [LEN_W-1:0]     fill_inc_s;
    logic                 hit_s;
    logic                 armed_s;

    // Length legality, shifted history, saturating fill and match decision
    always_comb begin
        len_ok_s   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(MAX_LEN));
        shift_s    = {hist_q[MAX_LEN-2:0], x};
        fill_inc_s = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : (fill_q + LEN_W'(1));
        mask_s     = {MAX_LEN{1'b0}};
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < 32'(len_q)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
        hit_s = (fill_inc_s >= len_q) && ((shift_s & mask_s) == (pat_q & mask_s));
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only a legal load changes state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_UNCFG: begin
                if (cfg_load && len_ok_s) begin
                    state_d = S_ARMED;
                end else begin
                    state_d = S_UNCFG;
                end
            end
            S_ARMED: begin
                state_d = S_ARMED;
            end
            default: begin
                state_d = S_UNCFG;
            end
        endcase
    end

    // Output decode of the FSM state
    always_comb begin
        armed_s = 1'b0;
        case (state_q)
            S_ARMED: armed_s = 1'b1;
            S_UNCFG: armed_s = 1'b0;
            default: armed_s = 1'b0;
        endcase
    end

    // Datapath next values: a load takes priority over enabled shifting
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        cnt_d  = cnt_q;
        z_d    = 1'b0;
        err_d  = 1'b0;
        if (cfg_load) begin
            if (len_ok_s) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = {MAX_LEN{1'b0}};
                fill_d = {LEN_W{1'b0}};
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                err_d = 1'b1;
            end
        end else if ((state_q == S_ARMED) && en) begin
            hist_d = shift_s;
            if (hit_s) begin
                z_d    = 1'b1;
                cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_W'(1));
                // Non-overlap mode restarts filling so matched bits are not reused
                fill_d = ovl_q ? fill_inc_s : {LEN_W{1'b0}};
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            hist_d = hist_q;
        end
    end

    // Datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= {MAX_LEN{1'b0}};
            fill_q <= {LEN_W{1'b0}};
            pat_q  <= {MAX_LEN{1'b0}};
            len_q  <= {LEN_W{1'b0}};
            ovl_q  <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            z_q    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
            err_q  <= err_d;
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign cfg_err     = err_q;
    assign armed       = armed_s;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Bench for param_sequence_detector (MAX_LEN=8, CNT_W=2): directed scenarios
// followed by randomized traffic, all compared against a queue-based model.
module tb_param_sequence_detector;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               x = 1'b0;
    logic               en = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               armed;

    int checks = 0;
    int errors = 0;

    // Reference model state: bits accepted since the last load or consumed match
    bit       m_armed = 1'b0;
    bit [7:0] m_pat = '0;
    int       m_len = 0;
    bit       m_ovl = 1'b0;
    int       m_cnt = 0;
    bit       m_q[$];
    bit       exp_z = 1'b0;
    bit       exp_err = 1'b0;

    param_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .x(x), .en(en), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .z(z), .match_count(match_count), .cfg_err(cfg_err), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input bit [7:0] p,
                              input int l, input bit o, input bit e, input bit xb);
        bit ok;
        exp_z   = 1'b0;
        exp_err = 1'b0;
        if (r) begin
            m_armed = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0; m_cnt = 0;
            m_q.delete();
        end else if (ld) begin
            if (l >= 1 && l <= MAX_LEN) begin
                m_armed = 1'b1; m_pat = p; m_len = l; m_ovl = o; m_cnt = 0;
                m_q.delete();
            end else begin
                exp_err = 1'b1;
            end
        end else if (m_armed && e) begin
            m_q.push_back(xb);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
                ok = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (m_q[m_q.size() - m_len + k] != m_pat[m_len - 1 - k]) ok = 1'b0;
                if (ok) begin
                    exp_z = 1'b1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    if (!m_ovl) m_q.delete();
                end
            end
        end
    endtask

    // Apply one cycle of inputs, then compare every output with the model
    task automatic drive(input bit r, input bit ld, input bit [7:0] p,
                         input bit [3:0] l, input bit o, input bit e, input bit xb);
        rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = l;
        cfg_overlap = o; en = e; x = xb;
        @(posedge clk);
        #1;
        model_step(r, ld, p, int'(l), o, e, xb);
        check("z", int'(z), int'(exp_z));
        check("cfg_err", int'(cfg_err), int'(exp_err));
        check("armed", int'(armed), int'(m_armed));
        check("match_count", int'(match_count), m_cnt);
    endtask

    task automatic bit_in(input bit xb);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, xb);
    endtask

    task automatic load(input bit [7:0] p, input bit [3:0] l, input bit o);
        drive(1'b0, 1'b1, p, l, o, 1'b1, 1'b1);
    endtask

    initial begin
        bit [6:0] s7;
        s7 = 7'b1101101;

        // Reset state
        drive(1'b1, 1'b1, 8'hFF, 4'd3, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        check("reset_armed", int'(armed), 0);

        // Overlapping 1101 over 1101101: two matches
        load(8'b0000_1101, 4'd4, 1'b1);
        for (int i = 6; i >= 0; i--) bit_in(s7[i]);
        check("ovl_count", int'(match_count), 2);

        // Non-overlapping: one match
        load(8'b0000_1101, 4'd4, 1'b0);
        for (int i = 6; i >= 0; i--) bit_in(s7[i]);
        check("novl_count", int'(match_count), 1);

        // Length 1: z high on three consecutive cycles
        load(8'b0000_0001, 4'd1, 1'b1);
        bit_in(1'b1); check("len1_z1", int'(z), 1);
        bit_in(1'b1); check("len1_z2", int'(z), 1);
        bit_in(1'b1); check("len1_z3", int'(z), 1);
        check("len1_count", int'(match_count), 3);

        // Enable gaps between bits 2 and 3
        load(8'b0000_1101, 4'd4, 1'b0);
        bit_in(1'b1); bit_in(1'b1);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        bit_in(1'b0); bit_in(1'b1);
        check("gap_z", int'(z), 1);
        check("gap_count", int'(match_count), 1);

        // Illegal loads while armed keep the current configuration
        load(8'hAA, 4'd0, 1'b1);
        check("len0_err", int'(cfg_err), 1);
        check("len0_armed", int'(armed), 1);
        load(8'hAA, 4'd9, 1'b1);
        check("len9_err", int'(cfg_err), 1);
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        check("keep_pat_z", int'(z), 1);
        check("keep_pat_count", int'(match_count), 2);

        // Saturation at 3, then a mid-stream reset
        load(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bit_in(1'b1);
            check("sat_z", int'(z), 1);
        end
        check("sat_count", int'(match_count), 3);
        load(8'b0000_0101, 4'd3, 1'b1);
        bit_in(1'b1); bit_in(1'b0);
        drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        check("rst_armed", int'(armed), 0);
        check("rst_count", int'(match_count), 0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        check("uncfg_z", int'(z), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            bit r, ld, o, e, xb;
            bit [7:0] p;
            bit [3:0] l;
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 19) == 0);
            p  = 8'($urandom());
            l  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 3));
            o  = 1'($urandom());
            e  = ($urandom_range(0, 3) != 0);
            xb = 1'($urandom());
            drive(r, ld, p, l, o, e, xb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
